// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around mem_arbiter.
// The arbiter takes the slave view; the fetch/data/memory environment takes the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_wr_en;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_addr, d_wr_en, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_addr, mem_wr_en, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_addr, d_wr_en, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_addr, mem_wr_en, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction in flight,
// with anti-starvation for fetch, a BUSY timeout and fetch-response cancellation on flush.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TIMER_LIM  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  starveCnt_q, starveCnt_d;
  logic [7:0]  timer_q, timer_d;
  logic        cancel_q, cancel_d;
  logic        fetchHi_q, fetchHi_d;

  logic [31:0] memAddr_q, memAddr_d;
  logic        memWrEn_q, memWrEn_d;
  logic [63:0] memWdata_q, memWdata_d;
  logic [7:0]  memWmask_q, memWmask_d;

  logic        ifRvalid_q, ifRvalid_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic        ifErr_q, ifErr_d;
  logic        dRvalid_q, dRvalid_d;
  logic [63:0] dRdata_q, dRdata_d;
  logic        dErr_q, dErr_d;

  logic        grantI, grantD, fetchStarved, fetchCancelled;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      timer_q     <= '0;
      cancel_q    <= 1'b0;
      fetchHi_q   <= 1'b0;
      memAddr_q   <= '0;
      memWrEn_q   <= 1'b0;
      memWdata_q  <= '0;
      memWmask_q  <= '0;
      ifRvalid_q  <= 1'b0;
      ifRdata_q   <= '0;
      ifErr_q     <= 1'b0;
      dRvalid_q   <= 1'b0;
      dRdata_q    <= '0;
      dErr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      timer_q     <= timer_d;
      cancel_q    <= cancel_d;
      fetchHi_q   <= fetchHi_d;
      memAddr_q   <= memAddr_d;
      memWrEn_q   <= memWrEn_d;
      memWdata_q  <= memWdata_d;
      memWmask_q  <= memWmask_d;
      ifRvalid_q  <= ifRvalid_d;
      ifRdata_q   <= ifRdata_d;
      ifErr_q     <= ifErr_d;
      dRvalid_q   <= dRvalid_d;
      dRdata_q    <= dRdata_d;
      dErr_q      <= dErr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    starveCnt_d    = starveCnt_q;
    timer_d        = timer_q;
    cancel_d       = cancel_q;
    fetchHi_d      = fetchHi_q;
    memAddr_d      = memAddr_q;
    memWrEn_d      = memWrEn_q;
    memWdata_d     = memWdata_q;
    memWmask_d     = memWmask_q;
    ifRvalid_d     = 1'b0;
    ifRdata_d      = ifRdata_q;
    ifErr_d        = ifErr_q;
    dRvalid_d      = 1'b0;
    dRdata_d       = dRdata_q;
    dErr_d         = dErr_q;
    grantI         = 1'b0;
    grantD         = 1'b0;
    fetchStarved   = bus.if_req && (starveCnt_q == STARVE_LIM);
    // A flush seen in the final BUSY_I cycle cancels just like an earlier one.
    fetchCancelled = cancel_q || bus.if_flush;

    case (state_q)
      IDLE: begin
        if (bus.d_req && !fetchStarved) begin
          grantD     = 1'b1;
          state_d    = BUSY_D;
          timer_d    = '0;
          cancel_d   = 1'b0;
          memAddr_d  = bus.d_addr;
          memWrEn_d  = bus.d_wr_en;
          memWdata_d = bus.d_wdata;
          memWmask_d = bus.d_wmask;
          if (bus.if_req && (starveCnt_q != STARVE_LIM)) begin
            starveCnt_d = starveCnt_q + 4'd1;
          end
        end else if (bus.if_req) begin
          grantI      = 1'b1;
          state_d     = BUSY_I;
          timer_d     = '0;
          cancel_d    = bus.if_flush;
          starveCnt_d = '0;
          fetchHi_d   = bus.if_addr[2];
          memAddr_d   = bus.if_addr & ~32'h7;
          memWrEn_d   = 1'b0;
          memWdata_d  = '0;
          memWmask_d  = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d  = IDLE;
          timer_d  = '0;
          cancel_d = 1'b0;
          if (state_q == BUSY_I) begin
            if (!fetchCancelled) begin
              ifRvalid_d = 1'b1;
              ifErr_d    = 1'b0;
              ifRdata_d  = fetchHi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end
          end else begin
            dRvalid_d = 1'b1;
            dErr_d    = 1'b0;
            if (!memWrEn_q) begin
              dRdata_d = bus.mem_rdata;
            end
          end
        end else if (timer_q == TIMER_LIM) begin
          state_d  = IDLE;
          timer_d  = '0;
          cancel_d = 1'b0;
          if (state_q == BUSY_I) begin
            if (!fetchCancelled) begin
              ifRvalid_d = 1'b1;
              ifErr_d    = 1'b1;
              ifRdata_d  = '0;
            end
          end else begin
            dRvalid_d = 1'b1;
            dErr_d    = 1'b1;
            dRdata_d  = '0;
          end
        end else begin
          timer_d = timer_q + 8'd1;
          if (state_q == BUSY_I) begin
            cancel_d = fetchCancelled;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants are combinational, so they are gated to stay low while reset is held.
  assign bus.if_gnt    = grantI & nrst;
  assign bus.d_gnt     = grantD & nrst;
  assign bus.if_rvalid = ifRvalid_q;
  assign bus.if_rdata  = ifRdata_q;
  assign bus.if_err    = ifErr_q;
  assign bus.d_rvalid  = dRvalid_q;
  assign bus.d_rdata   = dRdata_q;
  assign bus.d_err     = dErr_q;
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wr_en = memWrEn_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.mem_wmask = memWmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with STARVE_MAX = 4 and TIMEOUT = 8.
module tb_mem_arbiter;
  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #2;
    tests++; if (bus.if_gnt !== 1'b0) begin fails++; $display("[TB] FAIL rst_if_gnt: got %0h expected 0", bus.if_gnt); end
    tests++; if (bus.d_gnt !== 1'b0) begin fails++; $display("[TB] FAIL rst_d_gnt: got %0h expected 0", bus.d_gnt); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("[TB] FAIL rst_mem_req: got %0h expected 0", bus.mem_req); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL rst_mem_addr: got %0h expected 0", bus.mem_addr); end
    tests++; if (bus.if_rdata !== 32'h0) begin fails++; $display("[TB] FAIL rst_if_rdata: got %0h expected 0", bus.if_rdata); end
    tests++; if (bus.d_rdata !== 64'h0) begin fails++; $display("[TB] FAIL rst_d_rdata: got %0h expected 0", bus.d_rdata); end
    tests++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rvalid: got %0h/%0h expected 0/0", bus.if_rvalid, bus.d_rvalid); end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    #1;
    tests++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin fails++; $display("[TB] FAIL fetch_gnt: got if=%0h d=%0h expected if=1 d=0", bus.if_gnt, bus.d_gnt); end
    tick();
    bus.if_req = 1'b0;
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("[TB] FAIL fetch_mem_req: got %0h expected 1", bus.mem_req); end
    tests++; if (bus.mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL fetch_mem_addr: got %0h expected 100", bus.mem_addr); end
    tests++; if (bus.mem_wr_en !== 1'b0 || bus.mem_wmask !== 8'h0) begin fails++; $display("[TB] FAIL fetch_mem_wr: got %0h/%0h expected 0/0", bus.mem_wr_en, bus.mem_wmask); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hAABBCCDD_11223344;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0) begin fails++; $display("[TB] FAIL fetch_rvalid: got %0h err %0h expected 1 err 0", bus.if_rvalid, bus.if_err); end
    tests++; if (bus.if_rdata !== 32'hAABBCCDD) begin fails++; $display("[TB] FAIL fetch_rdata: got %0h expected aabbccdd", bus.if_rdata); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("[TB] FAIL fetch_mem_req_drop: got %0h expected 0", bus.mem_req); end
    tick();
    tests++; if (bus.if_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL fetch_rvalid_pulse: got %0h expected 0", bus.if_rvalid); end
  endtask

  task automatic test_arbitration();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20C;
    bus.d_req   = 1'b1;
    bus.d_wr_en = 1'b0;
    bus.d_addr  = 32'h200;
    #1;
    tests++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin fails++; $display("[TB] FAIL arb_first: got d=%0h if=%0h expected d=1 if=0", bus.d_gnt, bus.if_gnt); end
    tick();
    bus.d_req = 1'b0;
    tests++; if (bus.mem_addr !== 32'h200 || bus.mem_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL arb_d_addr: got %0h wr %0h expected 200 wr 0", bus.mem_addr, bus.mem_wr_en); end
    tests++; if (bus.if_gnt !== 1'b0) begin fails++; $display("[TB] FAIL arb_busy_gnt: got %0h expected 0", bus.if_gnt); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h11223344_55667788;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0) begin fails++; $display("[TB] FAIL arb_d_rvalid: got %0h err %0h expected 1 err 0", bus.d_rvalid, bus.d_err); end
    tests++; if (bus.d_rdata !== 64'h11223344_55667788) begin fails++; $display("[TB] FAIL arb_d_rdata: got %0h expected 1122334455667788", bus.d_rdata); end
    tests++; if (bus.if_gnt !== 1'b1) begin fails++; $display("[TB] FAIL arb_second_gnt: got %0h expected 1", bus.if_gnt); end
    tick();
    bus.if_req = 1'b0;
    tests++; if (bus.mem_addr !== 32'h208) begin fails++; $display("[TB] FAIL arb_i_addr: got %0h expected 208", bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hCAFEBABE_DEADBEEF;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFEBABE) begin fails++; $display("[TB] FAIL arb_i_rdata: got v=%0h %0h expected v=1 cafebabe", bus.if_rvalid, bus.if_rdata); end
    tick();
  endtask

  task automatic test_store();
    bus.d_req   = 1'b1;
    bus.d_wr_en = 1'b1;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 64'hFEEDFACE_00C0FFEE;
    bus.d_wmask = 8'hF0;
    #1;
    tests++; if (bus.d_gnt !== 1'b1) begin fails++; $display("[TB] FAIL store_gnt: got %0h expected 1", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0;
    tests++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h300) begin fails++; $display("[TB] FAIL store_mem: got wr %0h addr %0h expected wr 1 addr 300", bus.mem_wr_en, bus.mem_addr); end
    tests++; if (bus.mem_wdata !== 64'hFEEDFACE_00C0FFEE || bus.mem_wmask !== 8'hF0) begin fails++; $display("[TB] FAIL store_wdata: got %0h mask %0h expected feedface00c0ffee mask f0", bus.mem_wdata, bus.mem_wmask); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h5A5A5A5A_5A5A5A5A;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0) begin fails++; $display("[TB] FAIL store_done: got %0h err %0h expected 1 err 0", bus.d_rvalid, bus.d_err); end
    tests++; if (bus.d_rdata !== 64'h11223344_55667788) begin fails++; $display("[TB] FAIL store_rdata_hold: got %0h expected 1122334455667788", bus.d_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    logic expD;
    bus.d_req     = 1'b1;
    bus.d_wr_en   = 1'b0;
    bus.d_addr    = 32'h400;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h10;
    bus.mem_rdata = 64'h00000001_00000002;
    for (int i = 0; i < 6; i++) begin
      expD = (i != 4);
      #1;
      tests++; if (bus.d_gnt !== expD || bus.if_gnt !== !expD) begin fails++; $display("[TB] FAIL starve_grant%0d: got d=%0h if=%0h expected d=%0h if=%0h", i, bus.d_gnt, bus.if_gnt, expD, !expD); end
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    tests++; if (bus.if_rdata !== 32'h00000002) begin fails++; $display("[TB] FAIL starve_if_rdata: got %0h expected 2", bus.if_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    bus.d_req   = 1'b1;
    bus.d_wr_en = 1'b1;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 64'h01234567_89ABCDEF;
    bus.d_wmask = 8'h0F;
    #1;
    tests++; if (bus.d_gnt !== 1'b1) begin fails++; $display("[TB] FAIL tmo_gnt: got %0h expected 1", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0;
    tests++; if (bus.mem_addr !== 32'h80 || bus.mem_wmask !== 8'h0F || bus.mem_wr_en !== 1'b1) begin fails++; $display("[TB] FAIL tmo_mem: got addr %0h mask %0h wr %0h expected 80 0f 1", bus.mem_addr, bus.mem_wmask, bus.mem_wr_en); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (bus.mem_req !== 1'b1 || bus.d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL tmo_busy%0d: got req %0h rvalid %0h expected 1 0", k, bus.mem_req, bus.d_rvalid); end
      tick();
    end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("[TB] FAIL tmo_req_drop: got %0h expected 0", bus.mem_req); end
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_err: got rvalid %0h err %0h expected 1 1", bus.d_rvalid, bus.d_err); end
    tests++; if (bus.d_rdata !== 64'h0) begin fails++; $display("[TB] FAIL tmo_rdata: got %0h expected 0", bus.d_rdata); end
    tick();
    tests++; if (bus.d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL tmo_pulse: got %0h expected 0", bus.d_rvalid); end
  endtask

  task automatic test_flush();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    tests++; if (bus.if_gnt !== 1'b1) begin fails++; $display("[TB] FAIL flush_gnt: got %0h expected 1", bus.if_gnt); end
    tick();
    bus.if_req   = 1'b0;
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h77777777_66666666;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("[TB] FAIL flush_suppress: got rvalid %0h req %0h expected 0 0", bus.if_rvalid, bus.mem_req); end
    tests++; if (bus.if_rdata !== 32'h00000002) begin fails++; $display("[TB] FAIL flush_rdata_hold: got %0h expected 2", bus.if_rdata); end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    #1;
    tests++; if (bus.if_gnt !== 1'b1) begin fails++; $display("[TB] FAIL flush_next_gnt: got %0h expected 1", bus.if_gnt); end
    tick();
    bus.if_req = 1'b0;
    tests++; if (bus.mem_addr !== 32'h40) begin fails++; $display("[TB] FAIL flush_next_addr: got %0h expected 40", bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h99999999_88888888;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h99999999) begin fails++; $display("[TB] FAIL flush_next_data: got v=%0h %0h expected v=1 99999999", bus.if_rvalid, bus.if_rdata); end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h48;
    tick();
    bus.if_req    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.if_flush  = 1'b1;
    bus.mem_rdata = 64'h12121212_34343434;
    tick();
    bus.mem_ack  = 1'b0;
    bus.if_flush = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h99999999) begin fails++; $display("[TB] FAIL flush_at_ack: got v=%0h %0h expected v=0 99999999", bus.if_rvalid, bus.if_rdata); end
    bus.d_req   = 1'b1;
    bus.d_wr_en = 1'b0;
    bus.d_addr  = 32'h500;
    tick();
    bus.d_req     = 1'b0;
    bus.if_flush  = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hABCDEF01_23456789;
    tick();
    bus.if_flush = 1'b0;
    bus.mem_ack  = 1'b0;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'hABCDEF01_23456789) begin fails++; $display("[TB] FAIL flush_data_unaffected: got v=%0h %0h expected v=1 abcdef0123456789", bus.d_rvalid, bus.d_rdata); end
    tick();
  endtask

  task automatic test_idle_ack();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFFFFFF_FFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("[TB] FAIL idle_ack: got %0h/%0h/%0h expected 0/0/0", bus.if_rvalid, bus.d_rvalid, bus.mem_req); end
    tests++; if (bus.d_rdata !== 64'hABCDEF01_23456789) begin fails++; $display("[TB] FAIL idle_ack_rdata: got %0h expected abcdef0123456789", bus.d_rdata); end
  endtask

  task automatic test_reset_mid();
    bus.d_req   = 1'b1;
    bus.d_wr_en = 1'b0;
    bus.d_addr  = 32'h600;
    tick();
    bus.d_req = 1'b0;
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("[TB] FAIL rmid_busy: got %0h expected 1", bus.mem_req); end
    #2;
    nrst = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL rmid_async: got req %0h addr %0h expected 0 0", bus.mem_req, bus.mem_addr); end
    tick();
    tick();
    tests++; if (bus.d_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rmid_no_rvalid: got %0h expected 0", bus.d_rvalid); end
    nrst        = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h700;
    #1;
    tests++; if (bus.d_gnt !== 1'b1) begin fails++; $display("[TB] FAIL rmid_first_gnt: got %0h expected 1", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0;
    tests++; if (bus.mem_addr !== 32'h700) begin fails++; $display("[TB] FAIL rmid_addr: got %0h expected 700", bus.mem_addr); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h0F0F0F0F_F0F0F0F0;
    tick();
    bus.mem_ack = 1'b0;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 64'h0F0F0F0F_F0F0F0F0) begin fails++; $display("[TB] FAIL rmid_resume: got v=%0h %0h expected v=1 0f0f0f0ff0f0f0f0", bus.d_rvalid, bus.d_rdata); end
    tick();
  endtask

  // Inputs change one time unit after the rising edge; outputs are read before the next edge.
  initial begin
    tests         = 0;
    fails         = 0;
    nrst          = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wr_en   = 1'b0;
    bus.d_wdata   = '0;
    bus.d_wmask   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_starvation();
    test_timeout();
    test_flush();
    test_idle_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
